// File: rtl/pkt_stim_gen.sv
// Packet stimulus generator with an optional loopback checker.
// Define PKT_STIM_GEN_CHK_EN to build the checker; otherwise pkt_rx_cnt/err_cnt read 0.
module pkt_stim_gen #(
  parameter int DATA_W        = 134,
  parameter int PAYLOAD_BYTES = 16,
  parameter int CNT_W         = 16,
  parameter int GAP_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  pkt_num,
  input  logic [10:0]       pkt_len,
  input  logic [GAP_W-1:0]  gap_cycles,
  output logic              data_out_valid,
  output logic [DATA_W-1:0] data_out,
  input  logic              data_out_ready,
  output logic              busy,
  output logic              done,
  input  logic              chk_in_valid,
  input  logic [DATA_W-1:0] chk_in,
  output logic [CNT_W-1:0]  pkt_rx_cnt,
  output logic [CNT_W-1:0]  err_cnt
);
  localparam int MAX_WORDS = (2047 + PAYLOAD_BYTES - 1) / PAYLOAD_BYTES;
  localparam int WORD_W    = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    pkt_num_q;
  logic [CNT_W-1:0]    pkt_idx_q;
  logic [10:0]         len_q;
  logic [GAP_W-1:0]    gap_q;
  logic [GAP_W-1:0]    gap_cnt_q;
  logic [WORD_W-1:0]   words_q;
  logic [WORD_W-1:0]   word_idx_q;
  logic                valid_q;
  logic [DATA_W-1:0]   data_q;
  logic                busy_q;
  logic                done_q;

  logic [10:0]         len_clamp;
  logic [11:0]         len_round;
  logic [WORD_W-1:0]   words_in;
  logic                last_word;
  logic                last_pkt;
  logic                start_acc;
  logic [7:0]          gen_pkt_d;
  logic [WORD_W-1:0]   gen_k_d;
  logic [10:0]         gen_len_d;
  logic [WORD_W-1:0]   gen_words_d;
  logic [DATA_W-1:0]   word_d;

  // Builds word k of packet s: marker, valid-byte field on the tail, rolling byte pattern.
  function automatic logic [DATA_W-1:0] gen_word(input logic [7:0]        s,
                                                 input logic [WORD_W-1:0] k,
                                                 input logic [10:0]       len,
                                                 input logic [WORD_W-1:0] nwords);
    logic [DATA_W-1:0] w;
    int pos;
    w = '0;
    if (k == '0) begin
      w[DATA_W-1:DATA_W-2] = 2'b01;
    end else if (k == nwords - WORD_W'(1)) begin
      w[DATA_W-1:DATA_W-2] = 2'b10;
      w[DATA_W-3:DATA_W-6] = 4'(len % 11'(PAYLOAD_BYTES));
    end else begin
      w[DATA_W-1:DATA_W-2] = 2'b11;
    end
    for (int b = 0; b < PAYLOAD_BYTES; b++) begin
      pos = int'(k) * PAYLOAD_BYTES + b;
      if (pos < int'(len)) w[8*b +: 8] = 8'(int'(s) + pos);
    end
    return w;
  endfunction

  assign len_clamp = (pkt_len < 11'd60) ? 11'd60 : pkt_len;
  assign len_round = {1'b0, len_clamp} + 12'(PAYLOAD_BYTES - 1);
  assign words_in  = WORD_W'(len_round / 12'(PAYLOAD_BYTES));
  assign last_word = (word_idx_q == words_q - WORD_W'(1));
  assign last_pkt  = (pkt_idx_q == pkt_num_q - CNT_W'(1));
  assign start_acc = start && (state_q == IDLE);

  // One shared word builder: selects which (packet, word) goes out on the next edge.
  always_comb begin
    gen_pkt_d   = pkt_idx_q[7:0];
    gen_k_d     = word_idx_q + WORD_W'(1);
    gen_len_d   = len_q;
    gen_words_d = words_q;
    case (state_q)
      IDLE: begin
        gen_pkt_d   = 8'd0;
        gen_k_d     = '0;
        gen_len_d   = len_clamp;
        gen_words_d = words_in;
      end
      SEND: if (last_word) begin
        gen_pkt_d = pkt_idx_q[7:0] + 8'd1;
        gen_k_d   = '0;
      end
      GAP: gen_k_d = '0;
      default: ;
    endcase
    word_d = gen_word(gen_pkt_d, gen_k_d, gen_len_d, gen_words_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pkt_num_q  <= '0;
      pkt_idx_q  <= '0;
      len_q      <= 11'd60;
      gap_q      <= '0;
      gap_cnt_q  <= '0;
      words_q    <= '0;
      word_idx_q <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (start) begin
            pkt_num_q  <= pkt_num;
            len_q      <= len_clamp;
            gap_q      <= gap_cycles;
            words_q    <= words_in;
            pkt_idx_q  <= '0;
            word_idx_q <= '0;
            if (pkt_num == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= SEND;
              busy_q  <= 1'b1;
              valid_q <= 1'b1;
              data_q  <= word_d;
            end
          end
        end
        SEND: if (data_out_ready) begin
          if (!last_word) begin
            word_idx_q <= word_idx_q + WORD_W'(1);
            data_q     <= word_d;
          end else if (last_pkt) begin
            // busy stays high through the done cycle and drops in IDLE
            state_q <= IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b1;
          end else begin
            pkt_idx_q  <= pkt_idx_q + CNT_W'(1);
            word_idx_q <= '0;
            if (gap_q == '0) begin
              data_q <= word_d;
            end else begin
              state_q   <= GAP;
              valid_q   <= 1'b0;
              data_q    <= '0;
              gap_cnt_q <= gap_q;
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_W'(1)) begin
            state_q <= SEND;
            valid_q <= 1'b1;
            data_q  <= word_d;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out_valid = valid_q;
  assign data_out       = data_q;
  assign busy           = busy_q;
  assign done           = done_q;

`ifdef PKT_STIM_GEN_CHK_EN
  logic [CNT_W-1:0]  rx_cnt_q;
  logic [CNT_W-1:0]  err_cnt_q;
  logic [7:0]        chk_pkt_q;
  logic [WORD_W-1:0] chk_k_q;
  logic              chk_open_q;
  logic [1:0]        chk_mark;
  logic [DATA_W-1:0] chk_exp;
  logic              chk_bad;

  assign chk_mark = chk_in[DATA_W-1:DATA_W-2];

  always_comb begin
    chk_exp = gen_word(chk_pkt_q, (chk_mark == 2'b01) ? WORD_W'(0) : chk_k_q, len_q, words_q);
    if (chk_mark == 2'b01) chk_bad = chk_open_q || (chk_in != chk_exp);
    else                   chk_bad = !chk_open_q || (chk_in != chk_exp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt_q   <= '0;
      err_cnt_q  <= '0;
      chk_pkt_q  <= '0;
      chk_k_q    <= '0;
      chk_open_q <= 1'b0;
    end else if (start_acc) begin
      rx_cnt_q   <= '0;
      err_cnt_q  <= '0;
      chk_pkt_q  <= '0;
      chk_k_q    <= '0;
      chk_open_q <= 1'b0;
    end else if (chk_in_valid) begin
      if (chk_bad && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_W'(1);
      if (chk_mark == 2'b10) rx_cnt_q <= rx_cnt_q + CNT_W'(1);
      // A head word always (re)opens a packet at word 1 of the current index
      if (chk_mark == 2'b01) begin
        chk_open_q <= 1'b1;
        chk_k_q    <= WORD_W'(1);
      end else if (chk_open_q) begin
        if (chk_mark == 2'b10) begin
          chk_open_q <= 1'b0;
          chk_k_q    <= '0;
          chk_pkt_q  <= chk_pkt_q + 8'd1;
        end else if (chk_k_q != '1) begin
          chk_k_q <= chk_k_q + WORD_W'(1);
        end
      end
    end
  end

  assign pkt_rx_cnt = rx_cnt_q;
  assign err_cnt    = err_cnt_q;
`else
  logic unused_chk;
  assign unused_chk = chk_in_valid ^ (^chk_in) ^ start_acc;
  assign pkt_rx_cnt = '0;
  assign err_cnt    = '0;
`endif

endmodule
